mito_layer_sequencer: RTL
=========================

# mito_layer_sequencer

Layer-level sequencer for the MITO accelerator datapath. It accepts one layer descriptor per valid/ready handshake. For each output window it drives the load strobes of the bias, weight and IFM buffers in order, waits out the PE-array/ReLU/pool pipeline, then strobes the OFM write. It also presents the active datapath mode (convolution, fully-connected, max-pool) to the output mux. It replaces hard-wired strobe generation at the top level.

## Interface
Parameters:
- WIN_W, 16, width of the window-count field
- IFM_ROWS, 3, IFM rows loaded per CONVOL/FULLY window (1..4)
- POOL_ROWS, 2, IFM rows loaded per POOL window (1..4)
- PIPE_LAT, 3, cycles between the last IFM strobe and the OFM write (≥1)
- CONVOL, 2'b01, mode encoding
- FULLY, 2'b10, mode encoding
- POOL, 2'b11, mode encoding

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  reset; synchronous, active-low
- cfg_valid  in  1  descriptor valid
- cfg_ready  out  1  sequencer idle and able to accept a descriptor
- cfg_mode  in  2  layer mode
- cfg_windows  in  WIN_W  number of output windows in the layer
- abort  in  1  synchronous cancel of the current layer
- bias_read  out  1  bias buffer load strobe
- wgt_read  out  1  weight buffer load strobe
- ifm_read  out  4  one-hot IFM row load strobe; bit k loads row k
- mode  out  2  latched layer mode, driving the pool/ReLU output select
- ofm_write  out  1  OFM buffer capture strobe
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the layer completes
- err  out  1  one-cycle pulse when an illegal descriptor is rejected
- perf_cycles  out  32  busy-cycle count of the last layer (see Configuration)

## Operation
- States: IDLE, BIAS, WGT, IFM, WAIT, WRITE, DONE.
- **IDLE**
  - cfg_ready=1.
  - A handshake (cfg_valid & cfg_ready & !abort) latches mode and the remaining-window counter rem=cfg_windows.
- **Next state after a handshake**
  - cfg_mode==2'b00: err pulses, state stays IDLE, mode is unchanged.
  - cfg_windows==0: go to DONE; no strobes are issued.
  - CONVOL or FULLY: go to BIAS.
  - POOL: go to IFM.
- **BIAS:** bias_read=1 for 1 cycle, then WGT.
- **WGT:** wgt_read=1 for 1 cycle, then IFM.
  - CONVOL visits WGT once per layer.
  - FULLY visits WGT before every window.
- **IFM**
  - Row counter r runs 0..R-1, where R=IFM_ROWS, or POOL_ROWS in POOL mode.
  - ifm_read=(1<<r), one row per cycle; unused high bits stay 0.
  - After row R-1, go to WAIT.
- **WAIT:** PIPE_LAT cycles with all strobes low, then WRITE.
- **WRITE**
  - ofm_write=1 for 1 cycle; rem decrements.
  - rem becomes 0: go to DONE.
  - Otherwise: go to IFM (CONVOL/POOL) or WGT (FULLY).
- **DONE:** done=1 for 1 cycle, then IDLE.
- **abort**
  - Valid in any state; the next cycle is IDLE.
  - All strobes are low from that cycle; done is not pulsed.
  - abort in IDLE blocks a coincident handshake.
- cfg_valid outside IDLE is ignored (cfg_ready=0). No descriptor is queued.

## Timing
- All outputs are registered.
- Reset values while rst_n is low: cfg_ready, busy, done, err, all strobes, mode=2'b00, perf_cycles=0.
- cfg_ready rises in the first cycle after rst_n deasserts.
- Reset mid-layer behaves as abort, and additionally clears mode and perf_cycles.
- Cycle numbering: handshake at cycle 0; the first state is at cycle 1.
- Last ofm_write cycle:
  - CONVOL: 2+N·(IFM_ROWS+PIPE_LAT+1).
  - FULLY: 1+N·(IFM_ROWS+PIPE_LAT+2).
  - POOL: N·(POOL_ROWS+PIPE_LAT+1).
- done occurs one cycle after the last ofm_write; cfg_ready=1 the following cycle.
- rem is unsigned WIN_W bits. cfg_windows=2^WIN_W−1 completes without wrap.

## Configuration
- MITO_SEQ_PERF_EN defined:
  - perf_cycles counts cycles with busy=1.
  - It clears on handshake and holds its value after done or abort.
  - It saturates at 2^32−1.
- Not defined: perf_cycles is tied to 0 and the counter is not synthesized.

## Test plan
All scenarios use defaults (IFM_ROWS=3, POOL_ROWS=2, PIPE_LAT=3).
- CONVOL, windows=2:
  - bias_read @1, wgt_read @2.
  - ifm_read 001/010/100 @3-5, ofm_write @9.
  - ifm_read @10-12, ofm_write @16, done @17, cfg_ready @18.
- FULLY, windows=2:
  - bias_read @1, wgt_read @2 and @10.
  - ifm_read @3-5 and @11-13.
  - ofm_write @9 and @17, done @18.
- POOL, windows=1:
  - mode=11 from @1; ifm_read 01/10 @1-2.
  - No bias_read or wgt_read.
  - ofm_write @6, done @7.
- Boundary descriptors:
  - windows=0: done @1, no strobes.
  - cfg_mode=00: err @1, busy stays 0, cfg_ready stays 1.
  - cfg_valid held during busy: not accepted.
- Cancellation:
  - CONVOL windows=4, abort @7: all strobes 0 and cfg_ready=1 @8, done never pulses.
  - rst_n low @5: all outputs at reset values @6.
- With MITO_SEQ_PERF_EN, CONVOL windows=2: perf_cycles=17 after done.

Source files
------------

// File: rtl/mito_layer_sequencer.sv
// Layer-level strobe sequencer for the MITO datapath: bias/weight/IFM loads, pipeline wait, OFM write.
// Optional busy-cycle counter enabled by defining MITO_SEQ_PERF_EN.
module mito_layer_sequencer #(
  parameter int         WIN_W     = 16,
  parameter int         IFM_ROWS  = 3,
  parameter int         POOL_ROWS = 2,
  parameter int         PIPE_LAT  = 3,
  parameter logic [1:0] CONVOL    = 2'b01,
  parameter logic [1:0] FULLY     = 2'b10,
  parameter logic [1:0] POOL      = 2'b11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_mode,
  input  logic [WIN_W-1:0] cfg_windows,
  input  logic             abort,
  output logic             bias_read,
  output logic             wgt_read,
  output logic [3:0]       ifm_read,
  output logic [1:0]       mode,
  output logic             ofm_write,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      perf_cycles
);

  localparam int WCW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  typedef enum logic [2:0] {IDLE, BIAS, WGT, IFM, WAIT, WRITE, DONE} state_t;

  state_t           state_reg, state_next;
  logic [1:0]       row_reg, row_next;
  logic [WCW-1:0]   wcnt_reg, wcnt_next;
  logic [WIN_W-1:0] rem_reg, rem_next;
  logic [1:0]       mode_reg, mode_next;
  logic             err_next;
  logic             handshake;
  logic [1:0]       row_last;
  logic [3:0]       ifm_next;

  logic             cfg_ready_reg, busy_reg, bias_reg, wgt_reg, ofm_reg, done_reg, err_reg;
  logic [3:0]       ifm_reg;

  assign handshake = (state_reg == IDLE) && cfg_ready_reg && cfg_valid && !abort;
  assign row_last  = (mode_reg == POOL) ? 2'(POOL_ROWS - 1) : 2'(IFM_ROWS - 1);

  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    wcnt_next  = wcnt_reg;
    rem_next   = rem_reg;
    mode_next  = mode_reg;
    err_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (handshake) begin
          if (cfg_mode == 2'b00) begin
            err_next = 1'b1;
          end else begin
            mode_next = cfg_mode;
            rem_next  = cfg_windows;
            row_next  = 2'd0;
            if (cfg_windows == '0)
              state_next = DONE;
            else if (cfg_mode == POOL)
              state_next = IFM;
            else
              state_next = BIAS;
          end
        end
      end
      BIAS: state_next = WGT;
      WGT: begin
        state_next = IFM;
        row_next   = 2'd0;
      end
      IFM: begin
        if (row_reg == row_last) begin
          state_next = WAIT;
          wcnt_next  = '0;
        end else begin
          row_next = row_reg + 2'd1;
        end
      end
      WAIT: begin
        if (wcnt_reg == WCW'(PIPE_LAT - 1))
          state_next = WRITE;
        else
          wcnt_next = wcnt_reg + WCW'(1);
      end
      WRITE: begin
        rem_next = rem_reg - WIN_W'(1);
        // Test before decrementing so a full-scale window count never wraps.
        if (rem_reg == WIN_W'(1)) begin
          state_next = DONE;
        end else if (mode_reg == FULLY) begin
          state_next = WGT;
        end else begin
          state_next = IFM;
          row_next   = 2'd0;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort)
      state_next = IDLE;
  end

  // Strobes are decoded from the next state so every output comes straight from a flop.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_ifm
      assign ifm_next[gi] = (state_next == IFM) && (row_next == 2'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      row_reg       <= 2'd0;
      wcnt_reg      <= '0;
      rem_reg       <= '0;
      mode_reg      <= 2'b00;
      cfg_ready_reg <= 1'b0;
      busy_reg      <= 1'b0;
      bias_reg      <= 1'b0;
      wgt_reg       <= 1'b0;
      ifm_reg       <= 4'd0;
      ofm_reg       <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      row_reg       <= row_next;
      wcnt_reg      <= wcnt_next;
      rem_reg       <= rem_next;
      mode_reg      <= mode_next;
      cfg_ready_reg <= (state_next == IDLE);
      busy_reg      <= (state_next != IDLE);
      bias_reg      <= (state_next == BIAS);
      wgt_reg       <= (state_next == WGT);
      ifm_reg       <= ifm_next;
      ofm_reg       <= (state_next == WRITE);
      done_reg      <= (state_next == DONE);
      err_reg       <= err_next;
    end
  end

`ifdef MITO_SEQ_PERF_EN
  logic [31:0] perf_reg;

  always_ff @(posedge clk) begin
    if (!rst_n)
      perf_reg <= 32'd0;
    else if (handshake)
      perf_reg <= 32'd0;
    else if (busy_reg && (perf_reg != 32'hFFFF_FFFF))
      perf_reg <= perf_reg + 32'd1;
  end

  assign perf_cycles = perf_reg;
`else
  assign perf_cycles = 32'd0;
`endif

  assign cfg_ready = cfg_ready_reg;
  assign busy      = busy_reg;
  assign bias_read = bias_reg;
  assign wgt_read  = wgt_reg;
  assign ifm_read  = ifm_reg;
  assign ofm_write = ofm_reg;
  assign done      = done_reg;
  assign err       = err_reg;
  assign mode      = mode_reg;

endmodule
